// File: rtl/conv_pool_engine.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pool_engine
//  Purpose  : Streaming 3x3 conv (zero padded) / 2x2 max-pool with line buffers.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_pool_engine #(
   parameter int  DATA_W    = 8,
   parameter int  COEF_W    = 8,
   parameter int  MAX_WIDTH = 128,
   parameter int  DIM_W     = 8,
   localparam int ACC_W     = DATA_W + COEF_W + 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  cfg_mode,
   input  logic                  cfg_relu,
   input  logic [DIM_W-1:0]      cfg_width,
   input  logic [DIM_W-1:0]      cfg_height,
   input  logic [9*COEF_W-1:0]   cfg_weights,
   input  logic [COEF_W-1:0]     cfg_bias,
   input  logic [DATA_W-1:0]     in_pixel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [ACC_W-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);
   localparam int LB_AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 mode_q, relu_q, eof_q, out_valid_q;
   logic [DIM_W-1:0]     width_q, height_q, col_q, row_q, ocol_q, orow_q;
   logic [DIM_W:0]       flush_q;
   logic [9*COEF_W-1:0]  wts_q;
   logic [COEF_W-1:0]    bias_q;
   logic [ACC_W-1:0]     out_data_q;

   logic [DATA_W-1:0]    lb1_q [MAX_WIDTH];
   logic [DATA_W-1:0]    lb2_q [MAX_WIDTH];
   logic [DATA_W-1:0]    win_q [9];
   logic [DATA_W-1:0]    win_d [9];

   logic                 w_stall, w_push, w_last_px, w_primed, w_prod;
   logic [DATA_W-1:0]    w_pix;
   logic [LB_AW-1:0]     w_lb_idx;
   logic [ACC_W-1:0]     w_conv, w_pool, w_result;

   assign w_stall   = out_valid_q && !out_ready;
   assign w_pix     = (state_q == S_FLUSH) ? '0 : in_pixel;
   assign w_lb_idx  = col_q[LB_AW-1:0];
   assign w_last_px = (row_q == height_q - DIM_W'(1)) && (col_q == width_q - DIM_W'(1));
   // Conv output n appears once input n+W+1 arrives; flush pushes always produce.
   assign w_primed  = (state_q == S_FLUSH) || (row_q > DIM_W'(1)) ||
                      ((row_q == DIM_W'(1)) && (col_q != '0));
   assign w_prod    = w_push && (mode_q ? (row_q[0] && col_q[0]) : w_primed);
   assign w_result  = mode_q ? w_pool : w_conv;

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      w_push   = 1'b0;
      case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            in_ready = !w_stall && !eof_q;
            w_push   = in_valid && !w_stall && !eof_q;
            if (w_push && w_last_px) state_d = mode_q ? S_RUN : S_FLUSH;
            if (eof_q && !w_stall)   state_d = S_DONE;
         end
         S_FLUSH: begin
            w_push = (flush_q != '0) && !w_stall;
            if ((flush_q == '0) && !w_stall) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);
   assign done      = (state_q == S_DONE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   always_comb begin
      for (int i = 0; i < 9; i++) win_d[i] = win_q[i];
      for (int ky = 0; ky < 3; ky++) begin
         win_d[3*ky]   = win_q[3*ky+1];
         win_d[3*ky+1] = win_q[3*ky+2];
      end
      win_d[2] = lb2_q[w_lb_idx];
      win_d[5] = lb1_q[w_lb_idx];
      win_d[8] = w_pix;
   end

   // Padding uses the output pixel's own position, so stale wrap-around taps vanish.
   always_comb begin : p_conv
      logic signed [ACC_W-1:0] acc;
      logic signed [ACC_W-1:0] px_s;
      logic signed [ACC_W-1:0] wt_s;
      logic                    tap_ok;
      acc    = ACC_W'($signed(bias_q));
      px_s   = '0;
      wt_s   = '0;
      tap_ok = 1'b0;
      for (int ky = 0; ky < 3; ky++) begin
         for (int kx = 0; kx < 3; kx++) begin
            tap_ok = !(((ky == 0) && (orow_q == '0)) ||
                       ((ky == 2) && (orow_q == height_q - DIM_W'(1))) ||
                       ((kx == 0) && (ocol_q == '0)) ||
                       ((kx == 2) && (ocol_q == width_q - DIM_W'(1))));
            px_s   = tap_ok ? ACC_W'(win_d[3*ky+kx]) : '0;
            wt_s   = ACC_W'($signed(wts_q[(3*ky+kx)*COEF_W +: COEF_W]));
            acc    = acc + px_s * wt_s;
         end
      end
      w_conv = (relu_q && acc[ACC_W-1]) ? '0 : acc;
   end

   always_comb begin : p_pool
      logic [DATA_W-1:0] m_top, m_bot, m_all;
      m_top  = (win_d[4] > win_d[5]) ? win_d[4] : win_d[5];
      m_bot  = (win_d[7] > win_d[8]) ? win_d[7] : win_d[8];
      m_all  = (m_top > m_bot) ? m_top : m_bot;
      w_pool = ACC_W'(m_all);
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         lb2_q[w_lb_idx] <= lb1_q[w_lb_idx];
         lb1_q[w_lb_idx] <= w_pix;
         for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         relu_q      <= 1'b0;
         eof_q       <= 1'b0;
         width_q     <= '0;
         height_q    <= '0;
         wts_q       <= '0;
         bias_q      <= '0;
         col_q       <= '0;
         row_q       <= '0;
         ocol_q      <= '0;
         orow_q      <= '0;
         flush_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == S_IDLE) && start) begin
            mode_q   <= cfg_mode;
            relu_q   <= cfg_relu;
            width_q  <= cfg_width;
            height_q <= cfg_height;
            wts_q    <= cfg_weights;
            bias_q   <= cfg_bias;
            col_q    <= '0;
            row_q    <= '0;
            ocol_q   <= '0;
            orow_q   <= '0;
            eof_q    <= 1'b0;
            flush_q  <= '0;
         end
         if (w_push) begin
            if (col_q == width_q - DIM_W'(1)) begin
               col_q <= '0;
               row_q <= row_q + DIM_W'(1);
            end else begin
               col_q <= col_q + DIM_W'(1);
            end
            if ((state_q == S_RUN) && w_last_px) begin
               if (mode_q) eof_q   <= 1'b1;
               else        flush_q <= (DIM_W+1)'(width_q) + (DIM_W+1)'(1);
            end else if (state_q == S_FLUSH) begin
               flush_q <= flush_q - (DIM_W+1)'(1);
            end
         end
         if (w_prod && !mode_q) begin
            if (ocol_q == width_q - DIM_W'(1)) begin
               ocol_q <= '0;
               orow_q <= orow_q + DIM_W'(1);
            end else begin
               ocol_q <= ocol_q + DIM_W'(1);
            end
         end
         if (w_prod) begin
            out_valid_q <= 1'b1;
            out_data_q  <= w_result;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_pool_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_pool_engine
//  Purpose  : Directed self-checking bench for conv_pool_engine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_pool_engine;
   localparam int DATA_W = 8;
   localparam int COEF_W = 8;
   localparam int DIM_W  = 8;
   localparam int ACC_W  = DATA_W + COEF_W + 5;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic                 cfg_mode = 1'b0;
   logic                 cfg_relu = 1'b0;
   logic [DIM_W-1:0]     cfg_width = '0;
   logic [DIM_W-1:0]     cfg_height = '0;
   logic [9*COEF_W-1:0]  cfg_weights = '0;
   logic [COEF_W-1:0]    cfg_bias = '0;
   logic [DATA_W-1:0]    in_pixel = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [ACC_W-1:0]     out_data;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic                 busy;
   logic                 done;

   conv_pool_engine dut (
      .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_relu(cfg_relu),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_weights(cfg_weights),
      .cfg_bias(cfg_bias), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int     n_vec = 0;
   int     n_bad = 0;
   int     done_cnt = 0;
   bit     bp_en = 1'b0;
   longint got_q[$];
   longint exp_q[$];
   int     pix_q[$];
   int     wt[9];

   task automatic check(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   bit               prev_stall = 1'b0;
   bit               prev_rst = 1'b1;
   logic [ACC_W-1:0] prev_data = '0;
   always @(negedge clk) begin
      if (!prev_rst && prev_stall) begin
         check("hold_valid", out_valid, 1);
         check("hold_data", longint'($signed(out_data)), longint'($signed(prev_data)));
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready && !rst) got_q.push_back(longint'($signed(out_data)));
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_rst   = rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_in_ready"},  in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"},  longint'(out_data), 0);
      check({tag, "_busy"},      busy, 0);
      check({tag, "_done"},      done, 0);
   endtask

   // Configuration lines are scrambled after start to prove they were latched.
   task automatic start_frame(input bit mode, input bit relu, input int w, input int h, input int b);
      got_q.delete();
      cfg_mode   = mode;
      cfg_relu   = relu;
      cfg_width  = DIM_W'(w);
      cfg_height = DIM_W'(h);
      for (int i = 0; i < 9; i++) cfg_weights[i*COEF_W +: COEF_W] = COEF_W'(wt[i]);
      cfg_bias   = COEF_W'(b);
      start      = 1'b1;
      tick();
      start       = 1'b0;
      check("busy_after_start", busy, 1);
      check("ready_after_start", in_ready, 1);
      cfg_mode    = ~mode;
      cfg_relu    = ~relu;
      cfg_width   = DIM_W'(2);
      cfg_height  = DIM_W'(2);
      cfg_weights = ~cfg_weights;
      cfg_bias    = COEF_W'(b + 5);
   endtask

   task automatic feed(input int n, input bit spurious);
      int k = 0;
      int t = 0;
      while (k < n && t < 5000) begin
         in_valid = 1'b1;
         in_pixel = DATA_W'(pix_q[k]);
         start    = spurious && (k == 2);
         @(negedge clk);
         if (in_ready) k++;
         tick();
         t++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (k < n) check("feed_timeout", k, n);
   endtask

   task automatic wait_done();
      int t  = 0;
      int d0 = done_cnt;
      while (done_cnt == d0 && t < 5000) begin
         tick();
         t++;
      end
      repeat (3) tick();
      check("done_pulses", done_cnt - d0, 1);
      check("busy_after_done", busy, 0);
   endtask

   task automatic compare(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check(tag, got_q[i], exp_q[i]);
   endtask

   function automatic void conv_model(input bit relu, input int w, input int h, input int b);
      exp_q.delete();
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            longint s = b;
            for (int ky = 0; ky < 3; ky++) begin
               for (int kx = 0; kx < 3; kx++) begin
                  int rr = r + ky - 1;
                  int cc = c + kx - 1;
                  if (rr >= 0 && rr < h && cc >= 0 && cc < w)
                     s += longint'(wt[3*ky+kx]) * pix_q[rr*w+cc];
               end
            end
            if (relu && s < 0) s = 0;
            exp_q.push_back(s);
         end
      end
   endfunction

   task automatic run_identity_4x2(input string tag);
      for (int i = 0; i < 9; i++) wt[i] = (i == 4) ? 1 : 0;
      pix_q.delete();
      for (int i = 1; i <= 8; i++) pix_q.push_back(i);
      start_frame(1'b0, 1'b0, 4, 2, 0);
      feed(8, 1'b0);
      wait_done();
      exp_q = '{1, 2, 3, 4, 5, 6, 7, 8};
      compare(tag);
   endtask

   initial begin
      repeat (3) tick();
      chk_reset("reset");
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) wt[i] = 1;
      pix_q.delete();
      for (int i = 0; i < 9; i++) pix_q.push_back(1);
      start_frame(1'b0, 1'b0, 3, 3, 0);
      feed(9, 1'b1);
      wait_done();
      exp_q = '{4, 6, 4, 6, 9, 6, 4, 6, 4};
      compare("conv_ones");

      run_identity_4x2("conv_identity");

      for (int i = 0; i < 9; i++) wt[i] = -1;
      pix_q.delete();
      for (int i = 0; i < 9; i++) pix_q.push_back(255);
      start_frame(1'b0, 1'b1, 3, 3, -3);
      feed(9, 1'b0);
      wait_done();
      exp_q = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      compare("conv_relu");
      start_frame(1'b0, 1'b0, 3, 3, -3);
      feed(9, 1'b0);
      wait_done();
      exp_q = '{-1023, -1533, -1023, -1533, -2298, -1533, -1023, -1533, -1023};
      compare("conv_neg");

      pix_q.delete();
      for (int i = 0; i < 16; i++) pix_q.push_back(i);
      start_frame(1'b1, 1'b0, 4, 4, 0);
      feed(16, 1'b0);
      wait_done();
      exp_q = '{5, 7, 13, 15};
      compare("pool_4x4");
      pix_q.delete();
      for (int i = 0; i < 25; i++) pix_q.push_back(i);
      start_frame(1'b1, 1'b0, 5, 5, 0);
      feed(25, 1'b0);
      wait_done();
      exp_q = '{6, 8, 16, 18};
      compare("pool_5x5");

      for (int i = 0; i < 9; i++) wt[i] = int'($urandom_range(0, 255)) - 128;
      pix_q.delete();
      for (int i = 0; i < 64; i++) pix_q.push_back(int'($urandom_range(0, 255)));
      begin
         int b = int'($urandom_range(0, 255)) - 128;
         conv_model(1'b0, 8, 8, b);
         bp_en = 1'b1;
         start_frame(1'b0, 1'b0, 8, 8, b);
         feed(64, 1'b1);
         wait_done();
         bp_en = 1'b0;
         tick();
         compare("conv_bp");
      end

      for (int i = 0; i < 9; i++) wt[i] = (i == 4) ? 1 : 0;
      pix_q.delete();
      for (int i = 1; i <= 16; i++) pix_q.push_back(i);
      start_frame(1'b0, 1'b0, 4, 4, 0);
      feed(6, 1'b0);
      rst = 1'b1;
      tick();
      chk_reset("rst_run");
      rst = 1'b0;
      tick();
      start_frame(1'b0, 1'b0, 4, 4, 0);
      feed(16, 1'b0);
      check("in_flush_busy", busy, 1);
      rst = 1'b1;
      tick();
      chk_reset("rst_flush");
      rst = 1'b0;
      tick();
      run_identity_4x2("conv_after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/conv_pool_engine.md
# conv_pool_engine

Streaming 3x3 convolution / 2x2 max-pool engine with internal line buffers, generated zero padding and valid/ready handshakes on both sides. It accepts one frame of unsigned pixels in raster order and emits one frame of results in raster order. It sits between the feature-map reader and the result writer in the accelerator datapath. It is generalised over pixel width, coefficient width and maximum row length, and adds signed weights, bias, optional ReLU and frame-level control.

## Interface
- DATA_W, 8, unsigned pixel width
- COEF_W, 8, signed weight/bias width (two's complement)
- MAX_WIDTH, 128, maximum row length; line-buffer depth
- DIM_W, 8, width of cfg_width/cfg_height
- ACC_W, DATA_W+COEF_W+5, signed accumulator/output width (derived, not overridden)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches cfg_* in IDLE, ignored otherwise
- cfg_mode  in  1  0 = conv3x3 (same size, zero pad), 1 = maxpool2x2 (stride 2)
- cfg_relu  in  1  1 = clamp negative conv results to 0
- cfg_width  in  DIM_W  row length W, legal 2..MAX_WIDTH
- cfg_height  in  DIM_W  row count H, legal ≥2
- cfg_weights  in  9*COEF_W  w[i] at bits [i*COEF_W +: COEF_W]; i = 3*ky+kx, ky/kx 0..2 top-left first
- cfg_bias  in  COEF_W  signed, added to every conv result
- in_pixel  in  DATA_W  input pixel
- in_valid  in  1  input handshake
- in_ready  out  1  input handshake
- out_data  out  ACC_W  signed result; pool results zero-extended
- out_valid  out  1  output handshake
- out_ready  in  1  output handshake
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last output handshake

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: in_ready=0. On start, latch all cfg_* (held constant for the frame), clear row/column counters, and go to RUN.
- RUN: in_ready = !(out_valid && !out_ready). Each accepted pixel advances column counter c (0..W-1, wraps and increments row r) and shifts into the 2-row line buffer and the 3x3 window.
- conv3x3: output n (linear raster index, 0..W*H-1) is computed on the cycle that input n+W+1 is accepted.
  - Window taps outside the image (row -1, row H, col -1, col W) are forced to 0, using the output pixel's own (r,c), not the input counters.
  - Result = sum(w[i]*tap[i]) + bias, full precision in ACC_W.
  - If cfg_relu=1 and the result is negative, output 0.
- conv, after input W*H-1 is accepted: go to FLUSH. Generate W+1 internal zero pushes, one per cycle, each gated by the same stall condition as in_ready, producing the remaining W+1 outputs.
- maxpool2x2: output (r/2,c/2) = max of unsigned pixels (r-1,c-1), (r-1,c), (r,c-1), (r,c), computed when input (r,c) with r and c both odd is accepted.
  - For odd W or H, the last column/row is consumed and never pooled.
  - Output count is floor(W/2)*floor(H/2).
  - No FLUSH: after the last input, go to DONE once the output register drains.
- DONE: pulse done for one cycle, return to IDLE, busy=0.
- Output register: single stage.
  - It loads when a result is produced.
  - out_valid is held with out_data stable until out_ready.
  - A new result cannot be produced while out_valid && !out_ready, because in_ready and flush are gated.
- Inputs presented in IDLE or DONE are not accepted (in_ready=0).
- rst in any state: return to IDLE, discard the frame, clear counters; line-buffer contents are don't-care.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, state=IDLE.
- start accepted at edge t: busy=1 and in_ready=1 from t+1 (RUN).
- Result latency: out_valid rises the cycle after the producing input handshake or flush push (1-cycle registered).
- Throughput: one pixel per cycle in and one result per cycle out when out_ready=1 continuously.
- Simultaneous out_valid&&out_ready and a producing event in the same cycle: the register reloads, and out_valid stays high.
- done asserts the cycle after the final output handshake; busy falls in the same cycle done pulses.
- start asserted while busy: ignored, with no effect on the frame.

## Test plan
- conv, W=H=3, all pixels 1, w[i]=1, bias=0, relu=0, out_ready=1 -> outputs 4,6,4,6,9,6,4,6,4, then a single done pulse.
- conv, W=4, H=2, pixels 1..8, only w[4]=1 (identity) -> outputs 1..8 in order; the last 5 outputs come from FLUSH.
- conv, relu=1, pixels all 255, w[i]=-1, bias=-3 -> all outputs 0; same with relu=0 -> corner -1023, center -2298.
- maxpool, W=4, H=4, pixels 0..15 raster -> outputs 5,7,13,15; W=5, H=5 ramp -> 4 outputs, last column/row ignored.
- Backpressure: out_ready random 50%, conv 8x8 random -> output stream identical to the out_ready=1 run; out_data stable while stalled; no input accepted during a stall.
- rst asserted mid-RUN and mid-FLUSH -> all outputs at reset values next cycle; a new start runs a clean frame with correct results.
